// File: rtl/kmeans_feeder.sv
// kmeans_feeder: transmit side of the k-means accelerator stream interface.
// Fetches one job (CLUSTER_SIZE centroids, then DATA_SIZE points) from a
// synchronous source SRAM and sends it to the accelerator as one gap-free
// valid burst. It then collects CLUSTER_SIZE returned centroids into
// result0..3 and reports done, or done with timeout.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                one-cycle job request (honoured in IDLE only)
//   busy, done, timeout  sequencer status
//   src_en, src_addr     source SRAM read port (1-cycle read latency)
//   src_rdata            source SRAM read data
//   km_in_valid/data     stream to the accelerator
//   km_out_valid/data    result words from the accelerator
//   result0..result3     captured centroids, in return order
module kmeans_feeder #(
  parameter int unsigned       CLUSTER_SIZE = 4,
  parameter int unsigned       DATA_SIZE    = 4096,
  parameter int unsigned       ADDR_W       = 13,
  parameter int unsigned       TMO_W        = 24,
  parameter logic [TMO_W-1:0]  TMO_CYC      = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_rdata,
  output logic              km_in_valid,
  output logic [15:0]       km_in_data,
  input  logic              km_out_valid,
  input  logic [15:0]       km_out_data,
  output logic [15:0]       result0,
  output logic [15:0]       result1,
  output logic [15:0]       result2,
  output logic [15:0]       result3
);

  localparam int unsigned       TOTAL     = CLUSTER_SIZE + DATA_SIZE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [1:0]        LAST_BEAT = 2'(CLUSTER_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_WAIT_RES,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                src_en_q, src_en_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic                rd_vld_q, rd_vld_d;
  logic                in_valid_q, in_valid_d;
  logic [15:0]         in_data_q, in_data_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [1:0]          beat_q, beat_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [TMO_W-1:0]    tmo_inc;
  logic [15:0]         res_q [4];
  logic [15:0]         res_d [4];

  always_comb begin
    state_d    = state_q;
    src_en_d   = src_en_q;
    src_addr_d = src_addr_q;
    // rd_vld marks the cycle in which src_rdata carries a requested word
    rd_vld_d   = src_en_q;
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    busy_d     = busy_q;
    timeout_d  = timeout_q;
    beat_d     = beat_q;
    tmo_cnt_d  = tmo_cnt_q;
    res_d      = res_q;
    tmo_inc    = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    // address advance shared by FETCH and STREAM; terminal compare, no wrap
    if ((state_q == S_FETCH || state_q == S_STREAM) && src_en_q) begin
      if (src_addr_q == LAST_ADDR) begin
        src_en_d = 1'b0;
      end else begin
        src_addr_d = src_addr_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          src_addr_d = '0;
          src_en_d   = 1'b1;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          beat_d     = '0;
          tmo_cnt_d  = '0;
        end
      end
      S_FETCH: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_vld_q) begin
          in_valid_d = 1'b1;
          in_data_d  = src_rdata;
        end else begin
          in_valid_d = 1'b0;
          in_data_d  = '0;
          tmo_cnt_d  = '0;
          state_d    = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (km_out_valid) begin
          res_d[beat_q] = km_out_data;
          beat_d        = beat_q + 2'd1;
          tmo_cnt_d     = '0;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_inc >= TMO_CYC) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_en_q   <= 1'b0;
      src_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      beat_q     <= '0;
      tmo_cnt_q  <= '0;
      res_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      src_en_q   <= src_en_d;
      src_addr_q <= src_addr_d;
      rd_vld_q   <= rd_vld_d;
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      beat_q     <= beat_d;
      tmo_cnt_q  <= tmo_cnt_d;
      res_q      <= res_d;
    end
  end

  assign busy        = busy_q;
  assign done        = (state_q == S_DONE);
  assign timeout     = timeout_q;
  assign src_en      = src_en_q;
  assign src_addr    = src_addr_q;
  assign km_in_valid = in_valid_q;
  assign km_in_data  = in_data_q;
  assign result0     = res_q[0];
  assign result1     = res_q[1];
  assign result2     = res_q[2];
  assign result3     = res_q[3];

endmodule

// File: tb/tb_kmeans_feeder.sv
// Directed bench for kmeans_feeder with an 8-point job (12-word burst) and a
// 16-cycle result timeout. A small synchronous SRAM model supplies the job.
module tb_kmeans_feeder;

  localparam int unsigned CS    = 4;
  localparam int unsigned DS    = 8;
  localparam int unsigned AW    = 13;
  localparam int unsigned TW    = 24;
  localparam int unsigned TOTAL = CS + DS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, timeout;
  logic          src_en;
  logic [AW-1:0] src_addr;
  logic [15:0]   src_rdata;
  logic          km_in_valid;
  logic [15:0]   km_in_data;
  logic          km_out_valid;
  logic [15:0]   km_out_data;
  logic [15:0]   result0, result1, result2, result3;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];

  always #5 clk = ~clk;

  kmeans_feeder #(
    .CLUSTER_SIZE(CS),
    .DATA_SIZE(DS),
    .ADDR_W(AW),
    .TMO_W(TW),
    .TMO_CYC(24'd16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .src_en(src_en),
    .src_addr(src_addr),
    .src_rdata(src_rdata),
    .km_in_valid(km_in_valid),
    .km_in_data(km_in_data),
    .km_out_valid(km_out_valid),
    .km_out_data(km_out_data),
    .result0(result0),
    .result1(result1),
    .result2(result2),
    .result3(result3)
  );

  always @(posedge clk) begin
    if (src_en) src_rdata <= mem[src_addr[3:0]];
  end

  // expected source word k: 0x0101, 0x0202, ... 0x0C0C
  function automatic logic [15:0] word_at(int k);
    logic [7:0] b;
    b = 8'(k + 1);
    return {b, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, timeout, src_en, km_in_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, timeout, src_en, km_in_valid});
    end
    checks++;
    if (src_addr !== '0 || km_in_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr_data: got addr %0h data %h expected 0 0", src_addr, km_in_data);
    end
    checks++;
    if ({result0, result1, result2, result3} !== 64'h0) begin
      errors++;
      $display("FAIL reset_results: got %h %h %h %h expected 0", result0, result1, result2, result3);
    end
  endtask

  task automatic test_burst();
    int exp_addr;
    start_job();
    checks++;
    if (busy !== 1'b1 || src_en !== 1'b1 || src_addr !== '0 || km_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_accept: got busy %b en %b addr %0d valid %b expected 1 1 0 0",
               busy, src_en, src_addr, km_in_valid);
    end
    tick();
    checks++;
    if (src_addr !== 13'd1 || km_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL burst_fetch: got addr %0d valid %b expected 1 0", src_addr, km_in_valid);
    end
    tick();
    for (int k = 0; k < int'(TOTAL); k++) begin
      checks++;
      if (km_in_valid !== 1'b1 || km_in_data !== word_at(k)) begin
        errors++;
        $display("FAIL burst_word%0d: got valid %b data %h expected 1 %h", k, km_in_valid, km_in_data, word_at(k));
      end
      exp_addr = (k + 2 > int'(TOTAL) - 1) ? int'(TOTAL) - 1 : k + 2;
      checks++;
      if (src_addr !== AW'(exp_addr)) begin
        errors++;
        $display("FAIL burst_addr%0d: got %0d expected %0d", k, src_addr, exp_addr);
      end
      tick();
    end
    checks++;
    if (km_in_valid !== 1'b0 || km_in_data !== 16'h0 || src_en !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: got valid %b data %h en %b expected 0 0000 0", km_in_valid, km_in_data, src_en);
    end
  endtask

  task automatic test_results();
    logic [15:0] vals [4];
    int dcount;
    vals = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int i = 0; i < 4; i++) begin
      km_out_valid = 1'b1;
      km_out_data  = vals[i];
      tick();
      km_out_valid = 1'b0;
      km_out_data  = 16'h0;
      if (i < 3) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL results_early_done%0d: got %b expected 0", i, done);
        end
        tick();
        tick();
      end
    end
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL results_done: got done %b tmo %b busy %b expected 1 0 1", done, timeout, busy);
    end
    checks++;
    if ({result0, result1, result2, result3} !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      errors++;
      $display("FAIL results_values: got %h %h %h %h expected AAAA BBBB CCCC DDDD", result0, result1, result2, result3);
    end
    dcount = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) dcount++;
    end
    checks++;
    if (dcount != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL results_pulse: got extra done %0d busy %b expected 0 0", dcount, busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    int j;
    start_job();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (km_in_valid) n++;
      else if (n > 0) break;
      tick();
    end
    checks++;
    if (n != int'(TOTAL)) begin
      errors++;
      $display("FAIL tmo_burst_len: got %0d expected %0d", n, TOTAL);
    end
    j = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      j = c;
      if (done) break;
    end
    checks++;
    if (j != 16 || done !== 1'b1) begin
      errors++;
      $display("FAIL tmo_delay: got %0d cycles (done %b) expected 16", j, done);
    end
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_flag: got %b expected 1", timeout);
    end
    checks++;
    if ({result0, result1, result2, result3} !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      errors++;
      $display("FAIL tmo_results_kept: got %h %h %h %h expected AAAA BBBB CCCC DDDD", result0, result1, result2, result3);
    end
    tick();
    checks++;
    if (done !== 1'b0 || timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after: got done %b tmo %b busy %b expected 0 1 0", done, timeout, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] vals [4];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    start_job();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (km_in_valid) n++;
      else if (n > 0) break;
      start        = (n == 4);
      km_out_valid = (n == 4);
      km_out_data  = (n == 4) ? 16'h1234 : 16'h0;
      tick();
    end
    start        = 1'b0;
    km_out_valid = 1'b0;
    km_out_data  = 16'h0;
    checks++;
    if (n != int'(TOTAL)) begin
      errors++;
      $display("FAIL stray_burst_len: got %0d expected %0d", n, TOTAL);
    end
    checks++;
    if (result0 !== 16'hAAAA || timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stray_ignored: got r0 %h tmo %b busy %b expected AAAA 0 1", result0, timeout, busy);
    end
    for (int i = 0; i < 4; i++) begin
      km_out_valid = 1'b1;
      km_out_data  = vals[i];
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got %b expected 1", done);
    end
    // excess beat and start request land in the DONE cycle
    km_out_data = 16'h5555;
    start       = 1'b1;
    tick();
    km_out_valid = 1'b0;
    km_out_data  = 16'h0;
    start        = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after_done: got done %b busy %b expected 0 0", done, busy);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || km_in_valid !== 1'b0 || src_en !== 1'b0) begin
        errors++;
        $display("FAIL b2b_no_new_job%0d: got busy %b valid %b en %b expected 0 0 0", c, busy, km_in_valid, src_en);
      end
    end
    checks++;
    if ({result0, result1, result2, result3} !== 64'h1111_2222_3333_4444) begin
      errors++;
      $display("FAIL b2b_results: got %h %h %h %h expected 1111 2222 3333 4444", result0, result1, result2, result3);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int j;
    logic found;
    start_job();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (km_in_valid && km_in_data == 16'h0505) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_reach_word5: got not reached expected reached");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, timeout, src_en, km_in_valid} !== 5'b0 || km_in_data !== 16'h0 || src_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got flags %b data %h addr %0d expected 0",
               {busy, done, timeout, src_en, km_in_valid}, km_in_data, src_addr);
    end
    checks++;
    if ({result0, result1, result2, result3} !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_results: got %h %h %h %h expected 0", result0, result1, result2, result3);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_job();
    checks++;
    if (src_addr !== '0 || src_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_restart_addr: got addr %0d en %b expected 0 1", src_addr, src_en);
    end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (km_in_valid) begin
        checks++;
        if (km_in_data !== word_at(n)) begin
          errors++;
          $display("FAIL rstmid_word%0d: got %h expected %h", n, km_in_data, word_at(n));
        end
        n++;
      end else if (n > 0) begin
        break;
      end
      tick();
    end
    checks++;
    if (n != int'(TOTAL)) begin
      errors++;
      $display("FAIL rstmid_burst_len: got %0d expected %0d", n, TOTAL);
    end
    j = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      j = c;
      if (done) break;
    end
    checks++;
    if (j != 16 || timeout !== 1'b1 || {result0, result1, result2, result3} !== 64'h0) begin
      errors++;
      $display("FAIL rstmid_timeout: got %0d cycles tmo %b results %h%h%h%h expected 16 1 0",
               j, timeout, result0, result1, result2, result3);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = word_at(i);
    src_rdata    = 16'h0;
    start        = 1'b0;
    km_out_valid = 1'b0;
    km_out_data  = 16'h0;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_burst();
    test_results();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
